// File: rtl/multi_cycle_core.sv
// multi_cycle_core: multi-cycle RV32I-subset core on a unified memory port
// Ports: clk, rst (async active-low); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
// halted (only with ILLEGAL_TRAP_EN); instret retired-instruction count.
// Build option: define ILLEGAL_TRAP_EN to halt on unsupported instructions instead of retiring them as NOPs.
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, HALT
  } state_t;
  state_t state, state_n;
  logic [31:0] pc, oldpc, ir, a, b, imm, aluout, mdr, imm_d, opb, sum, alu, wd;
  logic [31:0] regs [32];
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal, retire, wr_en;
  assign opc = ir[6:0];
  assign f3 = ir[14:12];
  assign rd = ir[11:7];
  assign is_r = opc == 7'h33 && ((ir[31:25] == 7'h00 && f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) ||
                                 (ir[31:25] == 7'h20 && f3 == 3'd0));
  assign is_i = opc == 7'h13 && f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
  assign is_ld = opc == 7'h03 && f3 == 3'd2;
  assign is_st = opc == 7'h23 && f3 == 3'd2;
  assign is_br = opc == 7'h63 && f3[2:1] == 2'b00;
  assign is_jal = opc == 7'h6F;
  assign legal = is_r | is_i | is_ld | is_st | is_br | is_jal;
  assign imm_d = is_st  ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                 is_br  ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                 is_jal ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                          {{20{ir[31]}}, ir[31:20]};
  // ir[30] selects sub only for R-type; I-type always adds
  assign opb = state == EXEC_R ? b : imm;
  assign sum = (state == EXEC_R && ir[30]) ? a - opb : a + opb;
  assign alu = f3 == 3'd7 ? a & opb :
               f3 == 3'd6 ? a | opb :
               f3 == 3'd2 ? {31'b0, $signed(a) < $signed(opb)} : sum;
  assign wr_en = state inside {ALU_WB, MEM_WB, JAL};
  assign wd = state == JAL ? oldpc + 32'd4 : state == MEM_WB ? mdr : aluout;
  assign halted = TRAP && state == HALT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else state <= state_n;
  // mem_req is gated by rst so nothing is requested while reset is held
  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = pc;
    mem_wdata = b;
    retire = 1'b0;
    case (state)
      FETCH: begin
        mem_req = rst;
        state_n = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        state_n = is_r ? EXEC_R : is_i ? EXEC_I : (is_ld | is_st) ? MEM_ADR :
                  is_br ? BRANCH : is_jal ? JAL : TRAP ? HALT : FETCH;
        retire = !legal && !TRAP;
      end
      EXEC_R, EXEC_I: state_n = ALU_WB;
      MEM_ADR: state_n = is_ld ? MEM_RD : MEM_WR;
      MEM_RD: begin
        mem_req = rst;
        mem_addr = {aluout[31:2], 2'b00};
        state_n = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WR: begin
        mem_req = rst;
        mem_we = 1'b1;
        mem_addr = {aluout[31:2], 2'b00};
        state_n = mem_ready ? FETCH : MEM_WR;
        retire = mem_ready;
      end
      ALU_WB, MEM_WB, BRANCH, JAL: begin
        state_n = FETCH;
        retire = 1'b1;
      end
      HALT: state_n = HALT;
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      oldpc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      imm <= '0;
      aluout <= '0;
      mdr <= '0;
      instret <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (state == FETCH && mem_ready) begin
        ir <= mem_rdata;
        oldpc <= pc;
        pc <= pc + 32'd4;
      end
      if (state == DECODE) begin
        a <= regs[ir[19:15]];
        b <= regs[ir[24:20]];
        imm <= imm_d;
      end
      if (state == EXEC_R || state == EXEC_I) aluout <= alu;
      if (state == MEM_ADR) aluout <= a + imm;
      if (state == MEM_RD && mem_ready) mdr <= mem_rdata;
      if (wr_en && rd != 5'd0) regs[rd] <= wd;
      // ir[12] distinguishes bne from beq
      if ((state == BRANCH && ((a == b) != ir[12])) || state == JAL) pc <= oldpc + imm;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
endmodule

// File: tb/tb_multi_cycle_core.sv
// tb_multi_cycle_core: table-driven program vectors with a memory-transaction scoreboard
module tb_multi_cycle_core;
  logic clk = 1'b0, rst, mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;
  logic [31:0] mem [256];
  int wcnt, lat, n_chk, n_fail;
  logic hold, h_we;
  logic [31:0] h_addr, h_wd;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct {
    logic [15:0][31:0] prog;
    txn_t [15:0] tx;
    int ntx, lat, cyc;
    logic [31:0] ret;
    logic halt;
  } vec_t;
  vec_t v [8];
  txn_t exp_q [$];

  always #5 clk = ~clk;
  assign mem_ready = mem_req && (wcnt >= lat);
  assign mem_rdata = mem[mem_addr[9:2]];

  multi_cycle_core dut (.clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted), .instret(instret));

  function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], rs1[4:0], f3, rd[4:0], op};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 3'd0, rd, 7'h13); endfunction
  function automatic logic [31:0] lw(int rd, int rs1, int imm); return enc_i(imm, rs1, 3'd2, rd, 7'h03); endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, int rd, int rs1, int rs2);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:5], rs2[4:0], rs1[4:0], 3'd2, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] br(logic [2:0] f3, int rs1, int rs2, int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], rs2[4:0], rs1[4:0], f3, m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(int rd, int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic txn_t F(logic [31:0] a); return '{1'b0, a, 32'h0}; endfunction
  function automatic txn_t W(logic [31:0] a, logic [31:0] d); return '{1'b1, a, d}; endfunction

  task automatic put(int k, int a, logic [31:0] w); v[k].prog[a/4] = w; endtask
  task automatic ex(int k, txn_t t);
    v[k].tx[v[k].ntx] = t;
    v[k].ntx++;
  endtask
  task automatic setv(int k, int l, int c, logic [31:0] r, logic h);
    v[k].lat = l;
    v[k].cyc = c;
    v[k].ret = r;
    v[k].halt = h;
  endtask

  task automatic chk(string nm, logic [65:0] act, logic [65:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // one clock: sample at the current point, then advance past the rising edge to the next falling edge
  task automatic tick();
    txn_t t;
    if (hold)
      chk("hold_stable", {mem_req, mem_we, mem_addr, mem_we ? mem_wdata : 32'h0},
          {1'b1, h_we, h_addr, h_we ? h_wd : 32'h0});
    if (mem_req && mem_ready) begin
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        chk("txn", {1'b0, mem_we, mem_addr, mem_we ? mem_wdata : 32'h0}, {1'b0, t});
      end
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end
    hold = mem_req && !mem_ready;
    h_we = mem_we;
    h_addr = mem_addr;
    h_wd = mem_wdata;
    @(posedge clk);
    #1;
    wcnt = hold ? wcnt + 1 : 0;
    @(negedge clk);
  endtask
  task automatic run(int n); repeat (n) tick(); endtask

  task automatic do_reset();
    rst = 1'b0;
    hold = 1'b0;
    wcnt = 0;
    lat = 0;
    exp_q.delete();
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_req", mem_req, 0);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    lat = 0;
    wcnt = 0;
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v[k].prog = '0;
      v[k].tx = '0;
      v[k].ntx = 0;
    end
    // 0: addi/addi/add, result stored
    put(0, 0, addi(1, 0, 5)); put(0, 4, addi(2, 0, 7)); put(0, 8, enc_r(7'h00, 3'd0, 3, 1, 2));
    put(0, 12, sw(3, 0, 'h40)); put(0, 16, jal(0, 0));
    ex(0, F(0)); ex(0, F(4)); ex(0, F(8)); ex(0, F(12)); ex(0, W('h40, 12)); ex(0, F(16));
    setv(0, 0, 12, 3, 0);
    // 1: sub/slt/and/or with a negative operand
    put(1, 0, addi(1, 0, -3)); put(1, 4, addi(2, 0, 6)); put(1, 8, enc_r(7'h20, 3'd0, 3, 2, 1));
    put(1, 12, sw(3, 0, 'h40)); put(1, 16, enc_r(7'h00, 3'd2, 4, 1, 2)); put(1, 20, sw(4, 0, 'h44));
    put(1, 24, enc_r(7'h00, 3'd7, 5, 1, 2)); put(1, 28, sw(5, 0, 'h48));
    put(1, 32, enc_r(7'h00, 3'd6, 6, 1, 2)); put(1, 36, sw(6, 0, 'h4C)); put(1, 40, jal(0, 0));
    ex(1, F(0)); ex(1, F(4)); ex(1, F(8)); ex(1, F(12)); ex(1, W('h40, 9)); ex(1, F(16)); ex(1, F(20));
    ex(1, W('h44, 1)); ex(1, F(24)); ex(1, F(28)); ex(1, W('h48, 4)); ex(1, F(32)); ex(1, F(36));
    ex(1, W('h4C, 32'hFFFF_FFFF)); ex(1, F(40));
    setv(1, 0, 40, 10, 0);
    // 2: andi/ori/slti, signed compares both ways
    put(2, 0, addi(1, 0, 'hF0)); put(2, 4, enc_i('h3C, 1, 3'd7, 2, 7'h13)); put(2, 8, sw(2, 0, 'h40));
    put(2, 12, enc_i(-256, 1, 3'd6, 3, 7'h13)); put(2, 16, sw(3, 0, 'h44));
    put(2, 20, enc_i(-15, 3, 3'd2, 4, 7'h13)); put(2, 24, sw(4, 0, 'h48));
    put(2, 28, enc_i(-1, 1, 3'd2, 5, 7'h13)); put(2, 32, sw(5, 0, 'h4C)); put(2, 36, jal(0, 0));
    ex(2, F(0)); ex(2, F(4)); ex(2, F(8)); ex(2, W('h40, 'h30)); ex(2, F(12)); ex(2, F(16));
    ex(2, W('h44, 32'hFFFF_FFF0)); ex(2, F(20)); ex(2, F(24)); ex(2, W('h48, 1)); ex(2, F(28));
    ex(2, F(32)); ex(2, W('h4C, 0)); ex(2, F(36));
    setv(2, 0, 36, 9, 0);
    // 3: beq x1,x1,-8 at 0x10 goes back to 0x08
    put(3, 0, addi(1, 0, 1)); put(3, 4, jal(0, 12)); put(3, 8, sw(1, 0, 'h40)); put(3, 12, jal(0, 0));
    put(3, 16, br(3'd0, 1, 1, -8));
    ex(3, F(0)); ex(3, F(4)); ex(3, F(16)); ex(3, F(8)); ex(3, W('h40, 1)); ex(3, F(12));
    setv(3, 0, 10, 3, 0);
    // 4: beq unequal / bne equal fall through, bne unequal taken
    put(4, 0, addi(1, 0, 1)); put(4, 4, addi(2, 0, 2)); put(4, 8, br(3'd0, 1, 2, 16));
    put(4, 12, jal(0, 4)); put(4, 16, br(3'd1, 1, 1, 16)); put(4, 20, br(3'd1, 1, 2, 8));
    put(4, 24, sw(1, 0, 'h40)); put(4, 28, sw(2, 0, 'h44)); put(4, 32, jal(0, 0));
    ex(4, F(0)); ex(4, F(4)); ex(4, F(8)); ex(4, F(12)); ex(4, F(16)); ex(4, F(20)); ex(4, F(28));
    ex(4, W('h44, 2)); ex(4, F(32));
    setv(4, 0, 20, 6, 0);
    // 5: jal x5,+16 at 0x20 links 0x24; writes to x0 are dropped
    put(5, 0, addi(1, 0, 3)); put(5, 4, jal(0, 28)); put(5, 32, jal(5, 16)); put(5, 48, addi(0, 0, 9));
    put(5, 52, sw(5, 0, 'h40)); put(5, 56, sw(0, 0, 'h44)); put(5, 60, jal(0, 0));
    ex(5, F(0)); ex(5, F(4)); ex(5, F(32)); ex(5, F(48)); ex(5, F(52)); ex(5, W('h40, 'h24));
    ex(5, F(56)); ex(5, W('h44, 0)); ex(5, F(60));
    setv(5, 0, 14, 4, 0);
    // 6: sw then lw through address 8 with three wait cycles on every access
    put(6, 0, jal(0, 32)); put(6, 32, addi(3, 0, 12)); put(6, 36, sw(3, 0, 8)); put(6, 40, lw(4, 0, 8));
    put(6, 44, sw(4, 0, 'h40)); put(6, 48, jal(0, 0));
    ex(6, F(0)); ex(6, F(32)); ex(6, F(36)); ex(6, W(8, 12)); ex(6, F(40)); ex(6, F(8)); ex(6, F(44));
    ex(6, W('h40, 12)); ex(6, F(48));
    setv(6, 3, 44, 5, 0);
    // 7: unsupported opcode 7'h7F
    put(7, 0, 32'h0000_007F); put(7, 4, addi(1, 0, 7)); put(7, 8, sw(1, 0, 'h40)); put(7, 12, jal(0, 0));
    ex(7, F(0));
`ifdef ILLEGAL_TRAP_EN
    setv(7, 0, 2, 0, 1);
`else
    ex(7, F(4)); ex(7, F(8)); ex(7, W('h40, 7)); ex(7, F(12));
    setv(7, 0, 2, 1, 0);
`endif
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = v[k].prog[i];
      for (int i = 0; i < v[k].ntx; i++) exp_q.push_back(v[k].tx[i]);
      lat = v[k].lat;
      rst = 1'b1;
      #1;
      run(v[k].cyc);
      chk($sformatf("vec%0d_instret", k), instret, v[k].ret);
      chk($sformatf("vec%0d_halted", k), halted, v[k].halt);
      for (int c = 0; c < 300 && exp_q.size() != 0; c++) tick();
      chk($sformatf("vec%0d_txn_left", k), exp_q.size(), 0);
`ifdef ILLEGAL_TRAP_EN
      if (k == 7) begin
        int seen;
        seen = 0;
        repeat (10) begin
          if (mem_req) seen++;
          tick();
        end
        chk("halt_no_req", seen, 0);
        chk("halt_sticky", halted, 1);
      end
`endif
    end
    // reset asserted while a load waits for mem_ready
    do_reset();
    mem[0] = lw(1, 0, 'h40);
    exp_q.push_back(F(0));
    lat = 3;
    rst = 1'b1;
    #1;
    run(7);
    chk("rd_wait", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
    rst = 1'b0;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_instret", instret, 0);
    @(negedge clk);
    chk("abort_hold_req", mem_req, 0);
    hold = 1'b0;
    wcnt = 0;
    lat = 0;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
    chk("refetch_instret", instret, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter INSTRET_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_req  output  1  unified instruction/data memory request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 SHALL have port mem_addr  output  32  byte address, word-aligned.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  read data; sampled only in a cycle with mem_req=1 and mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  completes the current request.
REQ-011 SHALL have port halted  output  1  core stopped (ILLEGAL_TRAP_EN only; otherwise tied 0).
REQ-012 SHALL have port instret  output  INSTRET_W  count of retired instructions.

Function
REQ-013 SHALL implement RV32I subset: add, sub, and, or, slt (func7[5] selects sub); addi, andi, ori, slti; lw; sw; beq; bne; jal.
REQ-014 SHALL hold 32x32 register file internally; x0 reads 0; writes to x0 discarded.
REQ-015 SHALL be FSM with states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, HALT.
REQ-016 SHALL in FETCH drive mem_req=1, mem_we=0, mem_addr=PC; on mem_ready=1 latch IR<=mem_rdata, OLDPC<=PC, PC<=PC+4, go to DECODE; else stay.
REQ-017 SHALL in DECODE latch rs1/rs2 operands and extended immediate, then branch by opcode: R->EXEC_R, I-ALU->EXEC_I, lw/sw->MEM_ADR, beq/bne->BRANCH, jal->JAL.
REQ-018 SHALL in EXEC_R/EXEC_I compute ALU result into ALUOUT, then ALU_WB writes rd and returns to FETCH.
REQ-019 SHALL in MEM_ADR compute rs1+imm; lw->MEM_RD, sw->MEM_WR.
REQ-020 SHALL in MEM_RD/MEM_WR hold mem_req, mem_addr, mem_we, mem_wdata stable until mem_ready=1; MEM_RD then latches data and goes to MEM_WB; MEM_WR goes to FETCH.
REQ-021 SHALL in BRANCH compare operands; if taken (beq equal / bne unequal) PC<=OLDPC+imm; go to FETCH.
REQ-022 SHALL in JAL write rd<=OLDPC+4, PC<=OLDPC+imm; go to FETCH.
REQ-023 SHALL with mem_ready tied 1 take: R/I 4 cycles, lw 5, sw 4, branch 3, jal 3; each wait cycle adds 1.
REQ-024 SHALL increment instret by 1 on the cycle an instruction leaves its final state; wraps modulo 2^INSTRET_W.
REQ-025 SHALL keep mem_req=0 in every state other than FETCH, MEM_RD, MEM_WR.
REQ-026 SHALL treat arithmetic as 32-bit wrap; slt/slti signed; imm sign-extended per I/S/B/J format.

Reset
REQ-027 SHALL on rst=0 immediately force state FETCH, PC=RESET_PC, x1..x31=0, instret=0, halted=0, mem_req=0.
REQ-028 SHALL keep mem_req=0 while rst=0; first request issued in the first cycle after release.
REQ-029 SHALL abandon any outstanding memory request on reset assertion mid-access; no register or counter update.

Configuration
REQ-030 SHALL with ILLEGAL_TRAP_EN defined: unsupported opcode/func in DECODE -> HALT; halted=1, mem_req=0, only reset exits; instret not incremented.
REQ-031 SHALL without ILLEGAL_TRAP_EN: unsupported instruction retires as NOP (DECODE->FETCH, instret+1); halted=0.

Verification
REQ-032 SHALL cover: mem_ready=1, addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 -> x3=12, instret=3 after 12 cycles.
REQ-033 SHALL cover: sw x3,8(x0) then lw x4,8(x0), ready delayed 3 cycles per access -> write addr 0x8 data 12 held stable; x4=12.
REQ-034 SHALL cover: beq x1,x1,-8 at PC 0x10 -> next fetch addr 0x08; bne equal operands -> next fetch 0x14.
REQ-035 SHALL cover: jal x5,+16 at PC 0x20 -> x5=0x24, next fetch 0x30; addi x0,x0,9 -> x0 remains 0.
REQ-036 SHALL cover: rst low during MEM_RD wait -> mem_req drops same cycle, after release fetch at RESET_PC, instret=0.
REQ-037 SHALL cover: opcode 7'h7F -> with ILLEGAL_TRAP_EN halted=1, no further mem_req; without it, PC advances by 4, instret+1.
